frame_draw_scheduler: RTL and testbench
=======================================

Name: frame_draw_scheduler

Overview:
- Shares one full-screen VGA pixel sweep engine among NUM_REQ image sources, for example the title, level and game-over screens.
- Each source has its own 160x120, 3-bit colour ROM, addressed by a common address bus.
- The block arbitrates redraw requests round-robin and drives the shared ROM address linearly from 0 to 19199.
- It compensates for ROM read latency, muxes the granted ROM's q, and drives x_counter/y_counter/colour/oPlot to the VGA adapter.

Parameters:
- NUM_REQ, 4, number of requesting image sources.
- X_SCREEN_PIXELS, 160, pixels per row.
- Y_SCREEN_PIXELS, 120, rows per frame.
- ROM_LATENCY, 1, clocks from rom_address to valid rom_q (1 or 2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level redraw request per source.
- grant  out  NUM_REQ  one-hot; held for the entire sweep of the winning source.
- busy  out  1  high while a sweep or its latency flush is in progress.
- rom_address  out  15  shared ROM address, equal to y*160+x.
- rom_q  in  3*NUM_REQ  concatenated ROM outputs; source i occupies bits [3i+2:3i].
- x_counter  out  8  VGA x coordinate.
- y_counter  out  7  VGA y coordinate.
- colour  out  3  VGA pixel colour.
- oPlot  out  1  VGA write enable.
- oDone  out  1  frame-complete flag.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset). Under reset, the next edge forces:
  - state to S_IDLE
  - grant, busy, oPlot, oDone, rom_address, x_counter, y_counter, colour to 0
  - the round-robin pointer to 0
  - the latency pipeline to cleared
- Reset mid-sweep aborts the sweep immediately; no further oPlot is issued.
- FSM states: S_IDLE, S_SWEEP, S_FLUSH, S_DONE.
- S_IDLE:
  - If req is nonzero, select the winner by round-robin, starting the search at the pointer.
  - Register grant to the winner's one-hot and go to S_SWEEP. Grant is visible in the first S_SWEEP cycle, called G.
  - Set the pointer to winner+1, modulo NUM_REQ.
  - Clear oDone on this transition.
- S_SWEEP:
  - rom_address takes values 0..19199, one per cycle, during cycles G..G+19199.
  - Internal x advances 0..159 and wraps to 0, incrementing y. y runs 0..119.
  - After address 19199 is issued, go to S_FLUSH.
- S_FLUSH:
  - Lasts ROM_LATENCY cycles, draining the pipeline.
  - rom_address holds at 19199.
  - Then go to S_DONE.
- S_DONE:
  - oDone is set and held high.
  - Next state is S_IDLE.
- oDone stays high in S_IDLE until the next grant is issued.
- Latency:
  - x/y pass through a ROM_LATENCY-deep pipeline together with a valid bit.
  - colour = rom_q slice of the granted source, registered alongside the delayed x/y.
  - oPlot = the delayed valid bit.
  - Pixel (x,y) therefore appears at cycle G + y*160 + x + ROM_LATENCY. The final pixel (159,119) appears at cycle G+19199+ROM_LATENCY.
- busy is high from G through the cycle of the last oPlot, inclusive. oDone rises the following cycle.
- Requests:
  - req is sampled only in S_IDLE.
  - Changes to req during S_SWEEP/S_FLUSH/S_DONE are ignored.
  - A dropped request does not abort the sweep.
  - A request held high through a sweep is re-arbitrated against the others. Because the pointer has advanced past that source, any other pending source wins first.
- Minimum gap: one S_DONE cycle plus one S_IDLE cycle between consecutive sweeps.
- Width rules:
  - Address counter is 15 bits and compares to X_SCREEN_PIXELS*Y_SCREEN_PIXELS-1.
  - x compares to X_SCREEN_PIXELS-1 and y to Y_SCREEN_PIXELS-1.
  - No counter ever reaches 160, 120 or 19200.

Optional Feature:
- Macro: FRAME_SCHED_TRANSPARENT_EN.
- Defined: a delayed pixel whose colour is 3'b000 suppresses oPlot for that cycle. Black acts as transparent, so sprite screens can overlay the previous frame. Timing, busy and oDone are unchanged.
- Undefined: every valid pixel is plotted, including black.

Decomposition:
- Package frame_draw_pkg holds:
  - X_SCREEN_PIXELS, Y_SCREEN_PIXELS, FRAME_WORDS=19200, ADDR_W=15, COLOUR_W=3
  - the FSM state typedef (2-bit enum)
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant, winner index, valid.
  - Combinational, with the pointer register held in the parent.
- The latency pipeline and the sweep counters stay in frame_draw_scheduler.

Test Plan:
1. Reset, then req=4'b0010 for 1 cycle, ROM_LATENCY=1, with ROM1 modelled as q=address[2:0]:
   - grant=0010 from G
   - first oPlot at G+1 with (0,0,colour 0)
   - pixel (159,0) at G+160
   - pixel (0,1) at G+161
   - last oPlot (159,119) at G+19200
   - oDone high at G+19201
   - busy low at G+19201
2. req=4'b1111 held continuously: grants come in the order 0001, 0010, 0100, 1000, 0001; each sweep has exactly 19200 oPlot pulses.
3. req=4'b0001 pulsed, then dropped at G+5: the sweep still completes all 19200 pixels; after oDone, the block idles with grant=0.
4. Assert reset at G+1000: the next cycle shows oPlot=0, busy=0, grant=0, rom_address=0. A fresh req=4'b0100 restarts from address 0, and the pointer having reset to 0 is confirmed.
5. ROM_LATENCY=2: the pixel at address 500 is (20,3), appears at G+502, and its colour matches ROM[500].
6. With FRAME_SCHED_TRANSPARENT_EN, a ROM holding 3'b000 at even addresses and 3'b101 at odd addresses gives exactly 9600 oPlot pulses; without the macro it gives 19200.

Source files
------------

// File: rtl/frame_draw_pkg.sv
// Purpose: shared screen geometry, widths and sweep FSM encoding for the frame draw scheduler.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package frame_draw_pkg;

  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int FRAME_WORDS     = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int ADDR_W          = 15;
  localparam int COLOUR_W        = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_draw_scheduler_rr_arbiter.sv
// Purpose: combinational round-robin pick among NUM_REQ requests, search starting at the pointer.
// Latency: zero cycles; the pointer register lives in the parent.
// Backpressure: none; o_valid is low when disabled or when no request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_pointer,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_winner,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_rot;

  // Rotate the requests so bit 0 is the source the pointer names, then take the first set bit.
  always_comb begin
    w_rot    = NUM_REQ'({i_req, i_req} >> i_pointer);
    o_winner = '0;
    o_valid  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (i_enable && !o_valid && w_rot[j]) begin
        o_valid  = 1'b1;
        o_winner = PW'((int'(i_pointer) + j) % NUM_REQ);
      end
    end
    o_grant = o_valid ? (NUM_REQ'(1) << o_winner) : '0;
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Purpose: round-robin share of one full-screen pixel sweep among NUM_REQ ROM image sources.
// Latency: pixel at address a is plotted ROM_LATENCY cycles after rom_address shows a.
// Backpressure: none; requests are only sampled in idle. FRAME_SCHED_TRANSPARENT_EN makes black pixels transparent.
module frame_draw_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int X_SCREEN_PIXELS = frame_draw_pkg::X_SCREEN_PIXELS,
  parameter int Y_SCREEN_PIXELS = frame_draw_pkg::Y_SCREEN_PIXELS,
  parameter int ROM_LATENCY     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [14:0]          rom_address,
  input  logic [3*NUM_REQ-1:0] rom_q,
  output logic [7:0]           x_counter,
  output logic [6:0]           y_counter,
  output logic [2:0]           colour,
  output logic                 oPlot,
  output logic                 oDone
);

  import frame_draw_pkg::*;

  localparam int                PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);
  localparam logic [7:0]        LAST_X     = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0]        LAST_Y     = 7'(Y_SCREEN_PIXELS - 1);
  localparam logic [1:0]        LAST_FLUSH = 2'(ROM_LATENCY - 1);

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_x;
  logic [6:0]          r_y;
  logic [1:0]          r_flush_cnt;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_busy;
  logic                r_done;
  logic                r_vld_pipe [ROM_LATENCY];
  logic [7:0]          r_x_pipe   [ROM_LATENCY];
  logic [6:0]          r_y_pipe   [ROM_LATENCY];

  logic [NUM_REQ-1:0]  w_arb_grant;
  logic [PW-1:0]       w_arb_idx;
  logic                w_arb_vld;
  logic [COLOUR_W-1:0] w_q_sel;
  logic                w_pix_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .i_req     (req),
    .i_pointer (r_ptr),
    .i_enable  (r_state == S_IDLE),
    .o_grant   (w_arb_grant),
    .o_winner  (w_arb_idx),
    .o_valid   (w_arb_vld)
  );

  // Sweep FSM: arbitrate in idle, walk the frame address, drain the ROM latency, flag completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_flush_cnt <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arb_vld) begin
            r_grant <= w_arb_grant;
            r_ptr   <= (w_arb_idx == PW'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_state <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (r_addr == LAST_ADDR) begin
            // Address stays parked on the last word while the pipeline drains.
            r_flush_cnt <= '0;
            r_state     <= S_FLUSH;
          end else begin
            r_addr <= r_addr + 1'b1;
            if (r_x == LAST_X) begin
              r_x <= '0;
              r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == LAST_FLUSH) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Delay x/y and the issue strobe by the ROM read latency so they line up with rom_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        r_vld_pipe[i] <= 1'b0;
        r_x_pipe[i]   <= '0;
        r_y_pipe[i]   <= '0;
      end
    end else begin
      r_vld_pipe[0] <= (r_state == S_SWEEP);
      r_x_pipe[0]   <= r_x;
      r_y_pipe[0]   <= r_y;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_x_pipe[i]   <= r_x_pipe[i-1];
        r_y_pipe[i]   <= r_y_pipe[i-1];
      end
    end
  end

  // Select the granted source's ROM word; grant is one-hot so an AND-OR mux suffices.
  always_comb begin
    w_q_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_q_sel = w_q_sel | (rom_q[i*COLOUR_W +: COLOUR_W] & {COLOUR_W{r_grant[i]}});
    end
  end

  assign w_pix_vld   = r_vld_pipe[ROM_LATENCY-1];
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign oDone       = r_done;
  assign rom_address = r_addr;
  assign x_counter   = r_x_pipe[ROM_LATENCY-1];
  assign y_counter   = r_y_pipe[ROM_LATENCY-1];
  assign colour      = w_pix_vld ? w_q_sel : '0;

`ifdef FRAME_SCHED_TRANSPARENT_EN
  // Black is the transparent key: the slot is still consumed but nothing is written.
  assign oPlot = w_pix_vld && (w_q_sel != '0);
`else
  assign oPlot = w_pix_vld;
`endif

endmodule

// File: tb/tb_frame_draw_scheduler.sv
`timescale 1ns/1ps
module tb_frame_draw_scheduler;

  localparam int NR = 4;
  localparam int AX = 160, AY = 120, AL = 1;   // full-size frame
  localparam int BX = 160, BY = 4,   BL = 2;   // short frame, two-cycle ROM

`ifdef FRAME_SCHED_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  typedef struct { int cyc; int x; int y; int c; } pix_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- DUT A ----------------
  logic          rst_a = 1'b1;
  logic [NR-1:0] req_a = '0;
  logic [NR-1:0] gnt_a;
  logic          busy_a, plot_a, done_a;
  logic [14:0]   addr_a;
  logic [3*NR-1:0] q_a;
  logic [7:0]    x_a;
  logic [6:0]    y_a;
  logic [2:0]    col_a;

  frame_draw_scheduler #(.NUM_REQ(NR), .X_SCREEN_PIXELS(AX), .Y_SCREEN_PIXELS(AY), .ROM_LATENCY(AL)) dut_a (
    .clock(clock), .reset(rst_a), .req(req_a), .grant(gnt_a), .busy(busy_a),
    .rom_address(addr_a), .rom_q(q_a), .x_counter(x_a), .y_counter(y_a),
    .colour(col_a), .oPlot(plot_a), .oDone(done_a)
  );

  // ---------------- DUT B ----------------
  logic          rst_b = 1'b1;
  logic [NR-1:0] req_b = '0;
  logic [NR-1:0] gnt_b;
  logic          busy_b, plot_b, done_b;
  logic [14:0]   addr_b;
  logic [3*NR-1:0] q_b;
  logic [7:0]    x_b;
  logic [6:0]    y_b;
  logic [2:0]    col_b;

  frame_draw_scheduler #(.NUM_REQ(NR), .X_SCREEN_PIXELS(BX), .Y_SCREEN_PIXELS(BY), .ROM_LATENCY(BL)) dut_b (
    .clock(clock), .reset(rst_b), .req(req_b), .grant(gnt_b), .busy(busy_b),
    .rom_address(addr_b), .rom_q(q_b), .x_counter(x_b), .y_counter(y_b),
    .colour(col_b), .oPlot(plot_b), .oDone(done_b)
  );

  // ROM contents. A: source 1 returns address[2:0], the others are offset copies.
  function automatic logic [2:0] fa(input int s, input int a);
    return 3'(a + s + 7);
  endfunction
  // B: black at even addresses, a non-black per-source colour at odd ones (source 1 -> 3'b101).
  function automatic logic [2:0] fb(input int s, input int a);
    return (a % 2 == 1) ? 3'(4 + s) : 3'b000;
  endfunction

  // Synchronous ROM models with the configured read latency.
  logic [14:0] ad_a [AL] = '{default: '0};
  logic [14:0] ad_b [BL] = '{default: '0};
  always @(posedge clock) begin
    ad_a[0] <= addr_a;
    for (int i = 1; i < AL; i++) ad_a[i] <= ad_a[i-1];
    ad_b[0] <= addr_b;
    for (int i = 1; i < BL; i++) ad_b[i] <= ad_b[i-1];
  end
  always_comb begin
    q_a = '0;
    q_b = '0;
    for (int i = 0; i < NR; i++) begin
      q_a[3*i +: 3] = fa(i, int'(ad_a[AL-1]));
      q_b[3*i +: 3] = fb(i, int'(ad_b[BL-1]));
    end
  end

  // ---------------- scoreboard ----------------
  pix_t qa[$];
  pix_t qb[$];
  int plots_a = 0, plots_b = 0;
  pix_t pm_a, pm_b;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_pix(input string name, input pix_t e, input int c, input int x, input int y, input int col);
    vectors++;
    if (c != e.cyc || x != e.x || y != e.y || col != e.c) begin
      miscompares++;
      $display("FAIL %s: got cycle %0d (%0d,%0d) colour %0d, expected cycle %0d (%0d,%0d) colour %0d",
               name, c, x, y, col, e.cyc, e.x, e.y, e.c);
    end
  endtask

  task automatic push(input bit to_b, input int src, input int g, input int max_addr);
    for (int a = 0; a <= max_addr; a++) begin
      pix_t p;
      p.cyc = g + a + (to_b ? BL : AL);
      p.x   = a % (to_b ? BX : AX);
      p.y   = a / (to_b ? BX : AX);
      p.c   = to_b ? int'(fb(src, a)) : int'(fa(src, a));
      if (!(TRANSP && p.c == 0)) begin
        if (to_b) qb.push_back(p);
        else      qa.push_back(p);
      end
    end
  endtask

  // Monitor A: every plot must match the oldest outstanding expected pixel.
  always @(negedge clock) begin
    if (plot_a) begin
      plots_a++;
      if (qa.size() == 0) chk("A unexpected plot at cycle", cyc, -1);
      else begin
        pm_a = qa.pop_front();
        chk_pix("A pixel", pm_a, cyc, int'(x_a), int'(y_a), int'(col_a));
      end
    end
  end

  // Monitor B.
  always @(negedge clock) begin
    if (plot_b) begin
      plots_b++;
      if (qb.size() == 0) chk("B unexpected plot at cycle", cyc, -1);
      else begin
        pm_b = qb.pop_front();
        chk_pix("B pixel", pm_b, cyc, int'(x_b), int'(y_b), int'(col_b));
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Drive a request and return the first cycle grant is visible (-1 on timeout).
  task automatic start_a(input logic [NR-1:0] r, input logic [NR-1:0] exp, output int g);
    req_a = r;
    g = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (gnt_a != '0) begin g = cyc; break; end
    end
    chk("A grant", int'(gnt_a), int'(exp));
  endtask

  task automatic wait_grant_b(input int limit, output int g);
    g = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clock);
      if (gnt_b != '0) begin g = cyc; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fork
      // ===== DUT A: full frame, latency 1 =====
      begin
        int g;
        repeat (3) @(negedge clock);
        rst_a = 1'b0;
        @(negedge clock);
        chk("A reset grant", int'(gnt_a), 0);
        chk("A reset busy", int'(busy_a), 0);
        chk("A reset oPlot", int'(plot_a), 0);
        chk("A reset oDone", int'(done_a), 0);
        chk("A reset rom_address", int'(addr_a), 0);
        chk("A reset x", int'(x_a), 0);
        chk("A reset y", int'(y_a), 0);
        chk("A reset colour", int'(col_a), 0);

        // single-cycle request from source 1
        start_a(4'b0010, 4'b0010, g);
        req_a = '0;
        push(1'b0, 1, g, AX*AY-1);
        chk("A busy at G", int'(busy_a), 1);
        chk("A rom_address at G", int'(addr_a), 0);
        wait_until(g + 160);
        chk("A rom_address at G+160", int'(addr_a), 160);
        chk("A x at G+160", int'(x_a), 159);
        chk("A y at G+160", int'(y_a), 0);
        wait_until(g + 161);
        chk("A x at G+161", int'(x_a), 0);
        chk("A y at G+161", int'(y_a), 1);
        wait_until(g + AX*AY);
        chk("A last plot oPlot", int'(plot_a), 1);
        chk("A last plot busy", int'(busy_a), 1);
        chk("A flush rom_address", int'(addr_a), AX*AY-1);
        chk("A oDone before end", int'(done_a), 0);
        wait_until(g + AX*AY + 1);
        chk("A oDone at G+19201", int'(done_a), 1);
        chk("A busy at G+19201", int'(busy_a), 0);
        chk("A oPlot at G+19201", int'(plot_a), 0);
        wait_until(g + AX*AY + 4);
        chk("A idle grant", int'(gnt_a), 0);
        chk("A idle oDone held", int'(done_a), 1);

        // pointer is now 2: source 2 wins, then reset mid-sweep at G+1000
        start_a(4'b0100, 4'b0100, g);
        req_a = '0;
        chk("A oDone cleared on grant", int'(done_a), 0);
        push(1'b0, 2, g, 999);
        wait_until(g + 1000);
        rst_a = 1'b1;
        @(negedge clock);
        chk("A post-reset oPlot", int'(plot_a), 0);
        chk("A post-reset busy", int'(busy_a), 0);
        chk("A post-reset grant", int'(gnt_a), 0);
        chk("A post-reset rom_address", int'(addr_a), 0);
        rst_a = 1'b0;
        @(negedge clock);

        // pointer back at 0: with sources 2 and 3 pending, source 2 wins (3 would win from pointer 3)
        start_a(4'b1100, 4'b0100, g);
        req_a = '0;
        chk("A restart rom_address", int'(addr_a), 0);
        push(1'b0, 2, g, 49);
        wait_until(g + 50);
        rst_a = 1'b1;
        @(negedge clock);
        rst_a = 1'b0;
        chk("A second reset oPlot", int'(plot_a), 0);
        @(negedge clock);
      end

      // ===== DUT B: 160x4 frame, latency 2 =====
      begin
        int g, prev_g, p0;
        logic [NR-1:0] exp_g;
        repeat (3) @(negedge clock);
        rst_b = 1'b0;
        @(negedge clock);
        chk("B reset busy", int'(busy_b), 0);
        req_b = 4'b1111;
        prev_g = -1;
        for (int k = 0; k < 5; k++) begin
          exp_g = NR'(1) << (k % NR);
          wait_grant_b(2000, g);
          chk("B grant order", int'(gnt_b), int'(exp_g));
          if (g < 0) break;
          if (k > 0) chk("B inter-sweep gap", g - prev_g, BX*BY + BL + 2);
          push(1'b1, k % NR, g, BX*BY-1);
          p0 = plots_b;
          if (k == 0) begin
            wait_until(g + 502);
            chk("B x at addr 500", int'(x_b), 20);
            chk("B y at addr 500", int'(y_b), 3);
            chk("B colour at addr 500", int'(col_b), int'(fb(0, 500)));
            chk("B oPlot at addr 500", int'(plot_b), TRANSP ? 0 : 1);
          end
          if (k == 4) begin
            wait_until(g + 5);
            req_b = '0;
          end
          wait_until(g + BX*BY + BL);
          chk("B oDone at end", int'(done_b), 1);
          chk("B busy at end", int'(busy_b), 0);
          chk("B plots per sweep", plots_b - p0, TRANSP ? BX*BY/2 : BX*BY);
          prev_g = g;
        end
        wait_until(prev_g + BX*BY + BL + 6);
        chk("B idle grant after drop", int'(gnt_b), 0);
        chk("B idle busy after drop", int'(busy_b), 0);
        chk("B idle oDone held", int'(done_b), 1);
        chk("B idle rom_address held", int'(addr_b), BX*BY-1);
      end
    join

    chk("A missing plots", qa.size(), 0);
    chk("B missing plots", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if something wedges; every wait above is already bounded.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded 40000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
